// File: rtl/axis_bulk_packetiser.sv
// Byte-stream to USB packet framer: buffers AXI-Stream bytes and releases only closed
// frames (max length, tlast, idle timeout or flush) to the bulk IN channel.
module axis_bulk_packetiser #(
    parameter int MAX_PACKET = 512,
    parameter int DEPTH      = 2048,
    parameter int TIMEOUT    = 1024,
    localparam int ABITS     = $clog2(DEPTH)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             flush_i,
    input  logic             s_axis_tvalid_i,
    output logic             s_axis_tready_o,
    input  logic             s_axis_tlast_i,
    input  logic [7:0]       s_axis_tdata_i,
    output logic             m_axis_tvalid_o,
    input  logic             m_axis_tready_i,
    output logic             m_axis_tlast_o,
    output logic [7:0]       m_axis_tdata_o,
    output logic [ABITS:0]   level_o
);

    localparam int FW = $clog2(MAX_PACKET + 1);
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int PW = ABITS + 1;

    logic [8:0]    mem [DEPTH];
    logic [8:0]    ram_q;

    // rd_ptr frees a slot only once downstream takes the byte; fetch_ptr runs ahead
    // into the output/skid registers, so bytes in flight still count towards level.
    logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr, fetch_ptr;
    logic [PW-1:0] wr_ptr_n, cmt_ptr_n, rd_ptr_n, fetch_ptr_n;

    logic          hold_v, hold_close, hold_v_n, hold_close_n;
    logic [7:0]    hold_d, hold_d_n;
    logic [FW-1:0] fcnt, fcnt_n, fbase;
    logic [IW-1:0] idle_cnt, idle_cnt_n;
    logic          ready_r, ready_n;
    logic [PW-1:0] level_r, level_n;

    logic          out_v, out_l, skid_v, skid_l, pend;
    logic          out_v_n, out_l_n, skid_v_n, skid_l_n;
    logic [7:0]    out_d, skid_d, out_d_n, skid_d_n;

    logic          accept, timeout_hit, wr_en, wr_last;
    logic          pop, issue;
    logic [1:0]    occ;

    // Write side: hold register, frame counting and commit.
    always_comb begin
        accept       = s_axis_tvalid_i & ready_r;
        timeout_hit  = (TIMEOUT != 0) && (idle_cnt == IW'(TIMEOUT - 1));
        wr_en        = 1'b0;
        wr_last      = 1'b0;
        hold_v_n     = hold_v;
        hold_d_n     = hold_d;
        hold_close_n = hold_close;
        fbase        = fcnt;
        fcnt_n       = fcnt;

        if (accept) begin
            wr_en        = hold_v;
            wr_last      = hold_close;
            fbase        = (hold_v && hold_close) ? '0 : fcnt;
            fcnt_n       = fbase + FW'(1);
            hold_v_n     = 1'b1;
            hold_d_n     = s_axis_tdata_i;
            hold_close_n = s_axis_tlast_i | (fcnt_n == FW'(MAX_PACKET));
        end else if (hold_v && (hold_close || flush_i || timeout_hit)) begin
            wr_en        = 1'b1;
            wr_last      = 1'b1;
            hold_v_n     = 1'b0;
            hold_close_n = 1'b0;
            fcnt_n       = '0;
        end

        wr_ptr_n  = wr_ptr + PW'(wr_en);
        cmt_ptr_n = (wr_en && wr_last) ? (wr_ptr + PW'(1)) : cmt_ptr;

        if (accept || !hold_v)
            idle_cnt_n = '0;
        else if (idle_cnt != '1)
            idle_cnt_n = idle_cnt + IW'(1);
        else
            idle_cnt_n = idle_cnt;
    end

    // Read side: output register plus one skid slot keeps one byte per cycle
    // despite the registered RAM read.
    always_comb begin
        pop      = out_v & m_axis_tready_i;
        occ      = 2'(out_v) + 2'(skid_v) + 2'(pend) - 2'(pop);
        issue    = (fetch_ptr != cmt_ptr) && (occ < 2'd2);
        out_v_n  = out_v;
        out_d_n  = out_d;
        out_l_n  = out_l;
        skid_v_n = skid_v;
        skid_d_n = skid_d;
        skid_l_n = skid_l;

        if (!out_v || pop) begin
            if (skid_v) begin
                out_v_n  = 1'b1;
                out_d_n  = skid_d;
                out_l_n  = skid_l;
                skid_v_n = pend;
                if (pend) begin
                    skid_d_n = ram_q[7:0];
                    skid_l_n = ram_q[8];
                end
            end else if (pend) begin
                out_v_n = 1'b1;
                out_d_n = ram_q[7:0];
                out_l_n = ram_q[8];
            end else begin
                out_v_n = 1'b0;
            end
        end else if (pend) begin
            skid_v_n = 1'b1;
            skid_d_n = ram_q[7:0];
            skid_l_n = ram_q[8];
        end

        rd_ptr_n    = rd_ptr + PW'(pop);
        fetch_ptr_n = fetch_ptr + PW'(issue);
        level_n     = (wr_ptr_n - rd_ptr_n) + PW'(hold_v_n);
        ready_n     = level_n < PW'(DEPTH);
    end

    always_ff @(posedge aclk) begin
        if (wr_en && !areset)
            mem[wr_ptr[ABITS-1:0]] <= {wr_last, hold_d};
        if (issue && !areset)
            ram_q <= mem[fetch_ptr[ABITS-1:0]];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr     <= '0;
            cmt_ptr    <= '0;
            rd_ptr     <= '0;
            fetch_ptr  <= '0;
            hold_v     <= 1'b0;
            hold_d     <= '0;
            hold_close <= 1'b0;
            fcnt       <= '0;
            idle_cnt   <= '0;
            ready_r    <= 1'b0;
            level_r    <= '0;
            pend       <= 1'b0;
            out_v      <= 1'b0;
            out_d      <= '0;
            out_l      <= 1'b0;
            skid_v     <= 1'b0;
            skid_d     <= '0;
            skid_l     <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            cmt_ptr    <= cmt_ptr_n;
            rd_ptr     <= rd_ptr_n;
            fetch_ptr  <= fetch_ptr_n;
            hold_v     <= hold_v_n;
            hold_d     <= hold_d_n;
            hold_close <= hold_close_n;
            fcnt       <= fcnt_n;
            idle_cnt   <= idle_cnt_n;
            ready_r    <= ready_n;
            level_r    <= level_n;
            pend       <= issue;
            out_v      <= out_v_n;
            out_d      <= out_d_n;
            out_l      <= out_l_n;
            skid_v     <= skid_v_n;
            skid_d     <= skid_d_n;
            skid_l     <= skid_l_n;
        end
    end

    assign s_axis_tready_o = ready_r;
    assign m_axis_tvalid_o = out_v;
    assign m_axis_tdata_o  = out_d;
    assign m_axis_tlast_o  = out_l;
    assign level_o         = level_r;

endmodule
